// File: rtl/segmem_lookup_pkg.sv
// Shared widths, FSM state type and key-byte helper for the TCAM segment-memory front end.
package tcam_pkg;
    localparam int unsigned KWID    = 104;
    localparam int unsigned SEGWID  = 10;
    localparam int unsigned MASKWID = KWID / 8;
    localparam int unsigned VTWID   = SEGWID * MASKWID;
    localparam int unsigned AWID    = 8;
    localparam int unsigned DEP     = 1 << AWID;
    localparam int unsigned SIDXW   = 4;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    // k is 0-based: k=0 is key byte 1 (most significant byte)
    function automatic logic [AWID-1:0] key_byte(input logic [KWID-1:0] key, input int unsigned k);
        return key[KWID-1-8*k -: 8];
    endfunction
endpackage

// File: rtl/segmem_lookup_if.sv
// Search / rule-update / mask-vector bus between the key source and the segment-memory lookup.
interface segmem_lookup_if;
    import tcam_pkg::*;

    logic             i_Search_Valid;
    logic [KWID-1:0]  i_Search_Key;
    logic             o_Search_Ready;
    logic             i_Wr_En;
    logic [SIDXW-1:0] i_Wr_Seg;
    logic [AWID-1:0]  i_Wr_Addr;
    logic [VTWID-1:0] i_Wr_Data;
    logic             o_Wr_Err;
    logic             o_Init_Done;
    logic             o_Vector_Valid;
    logic [VTWID-1:0] o_Mask_Vector1,  o_Mask_Vector2,  o_Mask_Vector3,  o_Mask_Vector4;
    logic [VTWID-1:0] o_Mask_Vector5,  o_Mask_Vector6,  o_Mask_Vector7,  o_Mask_Vector8;
    logic [VTWID-1:0] o_Mask_Vector9,  o_Mask_Vector10, o_Mask_Vector11, o_Mask_Vector12;
    logic [VTWID-1:0] o_Mask_Vector13;

    modport master (
        output i_Search_Valid, i_Search_Key, i_Wr_En, i_Wr_Seg, i_Wr_Addr, i_Wr_Data,
        input  o_Search_Ready, o_Wr_Err, o_Init_Done, o_Vector_Valid,
        input  o_Mask_Vector1, o_Mask_Vector2, o_Mask_Vector3, o_Mask_Vector4, o_Mask_Vector5,
               o_Mask_Vector6, o_Mask_Vector7, o_Mask_Vector8, o_Mask_Vector9, o_Mask_Vector10,
               o_Mask_Vector11, o_Mask_Vector12, o_Mask_Vector13
    );

    modport slave (
        input  i_Search_Valid, i_Search_Key, i_Wr_En, i_Wr_Seg, i_Wr_Addr, i_Wr_Data,
        output o_Search_Ready, o_Wr_Err, o_Init_Done, o_Vector_Valid,
        output o_Mask_Vector1, o_Mask_Vector2, o_Mask_Vector3, o_Mask_Vector4, o_Mask_Vector5,
               o_Mask_Vector6, o_Mask_Vector7, o_Mask_Vector8, o_Mask_Vector9, o_Mask_Vector10,
               o_Mask_Vector11, o_Mask_Vector12, o_Mask_Vector13
    );
endinterface

// File: rtl/segmem_lookup_sp.sv
// Single-port segment memory: synchronous read-before-write, one word per cycle.
module segmem_sp
    import tcam_pkg::*;
(
    input  logic             clk,
    input  logic             we_i,
    input  logic [AWID-1:0]  addr_i,
    input  logic [VTWID-1:0] wdata_i,
    output logic [VTWID-1:0] rdata_o
);
    logic [VTWID-1:0] mem_q [DEP];
    logic [VTWID-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/segmem_lookup.sv
// Segment-memory lookup: zero-fill FSM, rule-update port and 13-way pipelined key-byte lookup.
module segmem_lookup
    import tcam_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    segmem_lookup_if.slave bus
);
    state_e                        state_q, state_d;
    logic [AWID-1:0]               sweep_q, sweep_d;
    logic                          init_fill, run, seg_ok, wr_ok, accept;
    logic                          v1_q, v2_q, err_q;
    logic [MASKWID-1:0][VTWID-1:0] rdata;
    logic [MASKWID-1:0][VTWID-1:0] vec_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        init_fill = 1'b0;
        run       = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_fill = 1'b1;
                sweep_d   = sweep_q + 1'b1;
                if (sweep_q == AWID'(DEP - 1)) state_d = ST_RUN;
            end
            ST_RUN:  run = 1'b1;
            default: state_d = ST_INIT;
        endcase
    end

    assign seg_ok = (bus.i_Wr_Seg != '0) && (bus.i_Wr_Seg <= SIDXW'(MASKWID));
    assign wr_ok  = run & bus.i_Wr_En & seg_ok;
    assign accept = bus.i_Search_Valid & bus.o_Search_Ready;

    assign bus.o_Search_Ready = run & ~bus.i_Wr_En;
    assign bus.o_Init_Done    = run;

    // Each memory port is shared: zero-fill, then update write, else the search read.
    for (genvar g = 0; g < MASKWID; g++) begin : g_seg
        logic            wr_hit;
        logic [AWID-1:0] addr;
        assign wr_hit = wr_ok && (bus.i_Wr_Seg == SIDXW'(g + 1));
        assign addr   = init_fill ? sweep_q :
                        wr_hit    ? bus.i_Wr_Addr : key_byte(bus.i_Search_Key, g);

        segmem_sp u_mem (
            .clk     (clk),
            .we_i    (init_fill | wr_hit),
            .addr_i  (addr),
            .wdata_i (init_fill ? '0 : bus.i_Wr_Data),
            .rdata_o (rdata[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            err_q <= 1'b0;
            vec_q <= '0;
        end else begin
            v1_q  <= accept;
            v2_q  <= v1_q;
            err_q <= bus.i_Wr_En & ~wr_ok;
            if (v1_q) vec_q <= rdata;
        end
    end

    assign bus.o_Wr_Err       = err_q;
    assign bus.o_Vector_Valid = v2_q;
    assign bus.o_Mask_Vector1  = vec_q[0];
    assign bus.o_Mask_Vector2  = vec_q[1];
    assign bus.o_Mask_Vector3  = vec_q[2];
    assign bus.o_Mask_Vector4  = vec_q[3];
    assign bus.o_Mask_Vector5  = vec_q[4];
    assign bus.o_Mask_Vector6  = vec_q[5];
    assign bus.o_Mask_Vector7  = vec_q[6];
    assign bus.o_Mask_Vector8  = vec_q[7];
    assign bus.o_Mask_Vector9  = vec_q[8];
    assign bus.o_Mask_Vector10 = vec_q[9];
    assign bus.o_Mask_Vector11 = vec_q[10];
    assign bus.o_Mask_Vector12 = vec_q[11];
    assign bus.o_Mask_Vector13 = vec_q[12];
endmodule
